phase_sequencer: RTL and testbench

- Controls the instruction decoder by generating its fetch and execute phase strobes `fe`, `e1` and `e2`.
- Steps through FETCH → E1 → optional E2 for each instruction. E2 is used by the memory-load instructions and, optionally, by the multi-cycle multiply.
- Handles halt on STP, run/idle control, memory wait-states and a retired-instruction counter.
- Sits between the top-level run control and the decoder/instruction memory. Its outputs drive the decoder phase inputs directly.

---
 rtl/phase_sequencer_if.sv | 42 ++++
 rtl/phase_sequencer.sv | 129 ++++++++++++
 tb/tb_phase_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if
// Groups the run-control, instruction/memory handshake and phase-strobe
// signals of the phase sequencer into one bundle.
//
//   master : run control / memory side (drives run, restart, instr,
//            mem_ready, mul_done; observes the strobes and status)
//   slave  : the sequencer itself
//
// Signals:
//   run, restart        run/idle level and HALT-exit pulse
//   instr[15:0]         current instruction word
//   mem_ready, mul_done E2 wait-state terminators
//   fe, e1, e2          decoder phase strobes
//   busy, halted        status
//   state[2:0]          IDLE=0 FETCH=1 E1=2 E2=3 HALT=4
//   instr_count         retired-instruction counter
interface phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             restart;
  logic [15:0]      instr;
  logic             mem_ready;
  logic             mul_done;
  logic             fe;
  logic             e1;
  logic             e2;
  logic             busy;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output run, restart, instr, mem_ready, mul_done,
    input  fe, e1, e2, busy, halted, state, instr_count
  );

  modport slave (
    input  run, restart, instr, mem_ready, mul_done,
    output fe, e1, e2, busy, halted, state, instr_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer
// Generates the decoder phase strobes fe/e1/e2 by stepping each instruction
// through FETCH -> E1 -> (optional) E2, with HALT on STP, run/idle control,
// data-memory wait states and a wrapping retired-instruction counter.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    phase_sequencer_if.slave (run, restart, instr, mem_ready,
//          mul_done in; fe, e1, e2, busy, halted, state, instr_count out)
//
// Build option:
//   SEQ_MUL_WAIT_EN  when defined, MLR (opcode 00111) uses E2 and waits for
//                    mul_done; otherwise MLR is single-execute and mul_done
//                    is ignored.
module phase_sequencer #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_E1    = 3'd2,
    ST_E2    = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             retire;

  // Opcode classification
  logic [4:0] opcode;
  logic       is_stp;
  logic       is_ldr;
  logic       is_lda;
  logic       needs_e2;  // instruction takes an E2 phase
  logic       wait_e2;   // E2 must be repeated this cycle

  assign opcode = bus.instr[15:11];
  assign is_stp = (opcode == 5'b00000);
  assign is_ldr = (opcode == 5'b01110);
  assign is_lda = (opcode[4:2] == 3'b110);

`ifdef SEQ_MUL_WAIT_EN
  logic is_mlr;
  assign is_mlr   = (opcode == 5'b00111);
  assign needs_e2 = is_lda | is_ldr | is_mlr;
  // instr stays valid through E2, so the wait source is re-derived from it
  assign wait_e2  = is_mlr ? ~bus.mul_done : ~bus.mem_ready;
`else
  assign needs_e2 = is_lda | is_ldr;
  assign wait_e2  = ~bus.mem_ready;
  logic unused_mul_done;
  assign unused_mul_done = bus.mul_done;
`endif

  // Operand field is of no interest to the sequencer
  logic unused_operand;
  assign unused_operand = ^bus.instr[10:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        state_next = ST_E1;
      end
      ST_E1: begin
        if (is_stp) begin
          state_next = ST_HALT;
          retire     = 1'b1;
        end else if (needs_e2) begin
          state_next = ST_E2;
        end else begin
          state_next = bus.run ? ST_FETCH : ST_IDLE;
          retire     = 1'b1;
        end
      end
      ST_E2: begin
        if (!wait_e2) begin
          state_next = bus.run ? ST_FETCH : ST_IDLE;
          retire     = 1'b1;
        end
      end
      ST_HALT: begin
        // run is deliberately ignored: HALT always resumes via IDLE
        if (bus.restart) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Counter wraps naturally at all-ones
  always_comb begin
    count_next = count_reg;
    if (retire) count_next = count_reg + CNT_W'(1);
  end

  // Outputs decode from registered state only
  assign bus.fe          = (state_reg == ST_FETCH);
  assign bus.e1          = (state_reg == ST_E1);
  assign bus.e2          = (state_reg == ST_E2);
  assign bus.busy        = (state_reg == ST_FETCH) || (state_reg == ST_E1) ||
                           (state_reg == ST_E2);
  assign bus.halted      = (state_reg == ST_HALT);
  assign bus.state       = state_reg;
  assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer
// Directed scenarios with literal expectations, then randomized traffic,
// all compared every cycle against an instruction-level model. A second,
// narrow-counter instance exercises counter wrap-around.
module tb_phase_sequencer;

`ifdef SEQ_MUL_WAIT_EN
  localparam bit MUL_WAIT = 1'b1;
`else
  localparam bit MUL_WAIT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst_w_n = 1'b0;

  always #5 clk = ~clk;

  phase_sequencer_if #(.CNT_W(16)) sq_if ();
  phase_sequencer_if #(.CNT_W(4))  w_if ();

  phase_sequencer #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sq_if)
  );

  phase_sequencer #(.CNT_W(4)) u_dut_w (
    .clk   (clk),
    .rst_n (rst_w_n),
    .bus   (w_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
  endtask

  // ---------------- instruction-level model ----------------
  // m_mode: 0 idle, 1 executing an instruction, 2 halted.
  // m_phase: how many cycles of the current instruction have elapsed
  // (0 = fetch cycle, 1 = first execute cycle, 2 = any later cycle).
  int          m_mode  = 0;
  int          m_phase = 0;
  int unsigned m_count = 0;

  function automatic bit takes_second_phase(input logic [15:0] w);
    logic [4:0] op;
    op = w[15:11];
    return (op[4:2] == 3'b110) || (op == 5'b01110) ||
           (MUL_WAIT && op == 5'b00111);
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_phase = 0;
    m_count = 0;
  endtask

  task automatic model_finish_instr();
    m_count = (m_count + 1) & 32'hFFFF;
    if (sq_if.run) m_phase = 0;
    else           m_mode  = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (sq_if.run) begin m_mode = 1; m_phase = 0; end
    end else if (m_mode == 2) begin
      if (sq_if.restart) m_mode = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (sq_if.instr[15:11] == 5'b00000) begin
        m_count = (m_count + 1) & 32'hFFFF;
        m_mode  = 2;
      end else if (takes_second_phase(sq_if.instr)) begin
        m_phase = 2;
      end else begin
        model_finish_instr();
      end
    end else begin
      if (MUL_WAIT && sq_if.instr[15:11] == 5'b00111) begin
        if (sq_if.mul_done) model_finish_instr();
      end else begin
        if (sq_if.mem_ready) model_finish_instr();
      end
    end
  endtask

  function automatic logic [7:0] model_outputs();
    logic [2:0] st;
    logic fe, e1, e2, busy, halted;
    busy   = (m_mode == 1);
    halted = (m_mode == 2);
    fe     = busy && m_phase == 0;
    e1     = busy && m_phase == 1;
    e2     = busy && m_phase == 2;
    st     = halted ? 3'd4 : (busy ? 3'(m_phase + 1) : 3'd0);
    return {fe, e1, e2, busy, halted, st};
  endfunction

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_outputs",
            {24'd0, sq_if.fe, sq_if.e1, sq_if.e2, sq_if.busy, sq_if.halted, sq_if.state},
            {24'd0, model_outputs()});
      check("cyc_count", {16'd0, sq_if.instr_count}, m_count & 32'hFFFF);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic go_idle();
    sq_if.run = 1'b0; sq_if.restart = 1'b1;
    sq_if.mem_ready = 1'b1; sq_if.mul_done = 1'b1;
    for (int i = 0; i < 20 && m_mode != 0; i++) tick();
    check("go_idle_timeout", {31'd0, m_mode == 0}, 32'd1);
    sq_if.restart = 1'b0; sq_if.mem_ready = 1'b0; sq_if.mul_done = 1'b0;
  endtask

  function automatic logic [15:0] pick_instr();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 7))
      0: w[15:11] = ($urandom_range(0, 3) == 0) ? 5'b00000 : 5'b00001;
      1: w[15:11] = 5'b01110;
      2, 3: w[15:11] = {3'b110, 2'($urandom)};
      4: w[15:11] = 5'b00111;
      5: w[15:11] = 5'b00001;
      default: if (w[15:11] == 5'b00000) w[15:11] = 5'b00010;
    endcase
    return w;
  endfunction

  initial begin
    logic [5:0]  fe_pat, e1_pat;
    logic [17:0] seq6;
    logic [20:0] seq7, seq7_want;
    int          e2_cnt, base;
    bit          saw3, stayed, fe_seen;

    sq_if.run = 1'b0; sq_if.restart = 1'b0; sq_if.instr = 16'h0800;
    sq_if.mem_ready = 1'b0; sq_if.mul_done = 1'b0;
    w_if.run = 1'b0; w_if.restart = 1'b0; w_if.instr = 16'h0800;
    w_if.mem_ready = 1'b0; w_if.mul_done = 1'b0;

    // Reset state
    #1;
    check("reset_state", {29'd0, sq_if.state}, 32'd0);
    check("reset_strobes", {27'd0, sq_if.fe, sq_if.e1, sq_if.e2, sq_if.busy, sq_if.halted}, 32'd0);
    check("reset_count", {16'd0, sq_if.instr_count}, 32'd0);
    cmp_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // Back-to-back single-execute
    sq_if.run = 1'b1; sq_if.instr = 16'h0800;
    fe_pat = '0; e1_pat = '0; saw3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      fe_pat[i] = sq_if.fe; e1_pat[i] = sq_if.e1;
      if (sq_if.state == 3'd3) saw3 = 1'b1;
    end
    sq_if.run = 1'b0;
    tick();
    check("adr_fe_pattern", {26'd0, fe_pat}, 32'b010101);
    check("adr_e1_pattern", {26'd0, e1_pat}, 32'b101010);
    check("adr_no_e2_state", {31'd0, saw3}, 32'd0);
    check("adr_count", {16'd0, sq_if.instr_count}, 32'd3);
    check("adr_idle", {29'd0, sq_if.state}, 32'd0);
    $display("scenario adr: count=%0d", sq_if.instr_count);

    // LDA with two wait states
    go_idle();
    base = int'(sq_if.instr_count);
    sq_if.run = 1'b1; sq_if.instr = 16'hC005; sq_if.mem_ready = 1'b0;
    seq6 = '0; e2_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      seq6 = {seq6[14:0], sq_if.state};
      e2_cnt += int'(sq_if.e2);
      if (i == 5) sq_if.mem_ready = 1'b1;
    end
    check("lda_sequence", {14'd0, seq6}, 32'o123331);
    check("lda_e2_cycles", e2_cnt, 32'd3);
    check("lda_count", {16'd0, sq_if.instr_count}, base + 1);
    $display("scenario lda: seq=%o e2=%0d", seq6, e2_cnt);

    // STP, halt hold, restart
    sq_if.instr = 16'h0800;
    go_idle();
    base = int'(sq_if.instr_count);
    sq_if.run = 1'b1; sq_if.instr = 16'h0000;
    repeat (3) tick();
    check("stp_state", {29'd0, sq_if.state}, 32'd4);
    check("stp_halt_busy", {30'd0, sq_if.halted, sq_if.busy}, 32'b10);
    check("stp_count", {16'd0, sq_if.instr_count}, base + 1);
    stayed = 1'b1;
    repeat (10) begin tick(); if (sq_if.state != 3'd4) stayed = 1'b0; end
    check("stp_halt_hold", {31'd0, stayed}, 32'd1);
    sq_if.restart = 1'b1; tick(); sq_if.restart = 1'b0;
    check("restart_idle", {29'd0, sq_if.state}, 32'd0);
    tick();
    check("restart_fetch", {29'd0, sq_if.state}, 32'd1);
    sq_if.instr = 16'h0800;
    $display("scenario stp: halted then resumed");

    // LDR with run dropped during E2
    go_idle();
    sq_if.run = 1'b1; sq_if.instr = 16'h7000; sq_if.mem_ready = 1'b0;
    tick(); tick();
    sq_if.run = 1'b0;
    tick(); tick();
    check("ldr_still_e2", {29'd0, sq_if.state}, 32'd3);
    sq_if.mem_ready = 1'b1;
    tick();
    check("ldr_then_idle", {29'd0, sq_if.state}, 32'd0);
    fe_seen = 1'b0;
    repeat (3) begin tick(); if (sq_if.fe) fe_seen = 1'b1; end
    check("ldr_no_fetch", {31'd0, fe_seen}, 32'd0);
    sq_if.mem_ready = 1'b0;
    $display("scenario ldr: run drop completes then idles");

    // Asynchronous reset in E2
    go_idle();
    sq_if.run = 1'b1; sq_if.instr = 16'hC005; sq_if.mem_ready = 1'b0;
    repeat (3) tick();
    check("pre_reset_e2", {31'd0, sq_if.e2}, 32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_e2", {31'd0, sq_if.e2}, 32'd0);
    check("async_rst_state", {29'd0, sq_if.state}, 32'd0);
    check("async_rst_count", {16'd0, sq_if.instr_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    sq_if.run = 1'b0; sq_if.instr = 16'h0800;
    $display("scenario async reset: cleared mid-E2");

    // MLR with mul_done delayed
    go_idle();
    sq_if.run = 1'b1; sq_if.instr = 16'h3800;
    sq_if.mul_done = 1'b0; sq_if.mem_ready = 1'b0;
    seq7 = '0; e2_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      seq7 = {seq7[17:0], sq_if.state};
      e2_cnt += int'(sq_if.e2);
      if (i == 6) sq_if.mul_done = 1'b1;
    end
    seq7_want = MUL_WAIT ? 21'o1233331 : 21'o1212121;
    check("mlr_sequence", {11'd0, seq7}, {11'd0, seq7_want});
    check("mlr_e2_cycles", e2_cnt, MUL_WAIT ? 32'd4 : 32'd0);
    $display("scenario mlr: seq=%o e2=%0d", seq7, e2_cnt);
    sq_if.instr = 16'h0800;
    go_idle();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      sq_if.run       = ($urandom_range(0, 3) != 0);
      sq_if.restart   = ($urandom_range(0, 7) == 0);
      sq_if.mem_ready = ($urandom_range(0, 2) == 0);
      sq_if.mul_done  = ($urandom_range(0, 2) == 0);
      if (!(m_mode == 1 && m_phase >= 1)) sq_if.instr = pick_instr();
      if ($urandom_range(0, 999) == 0) begin
        #1 rst_n = 1'b0;
        model_reset();
      end
      tick();
      rst_n = 1'b1;
    end
    $display("scenario random: count=%0d", sq_if.instr_count);
    go_idle();

    // Counter wrap on the narrow instance
    w_if.run = 1'b1; w_if.instr = 16'h0800;
    rst_w_n = 1'b1;
    repeat (31) tick();
    check("wrap_all_ones", {28'd0, w_if.instr_count}, 32'hF);
    repeat (2) tick();
    check("wrap_to_zero", {28'd0, w_if.instr_count}, 32'h0);
    $display("scenario wrap: count=%0d", w_if.instr_count);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
